// File: rtl/sha_mem_arbiter.sv
// sha_mem_arbiter: shares the SoC RAM native port between the core (master 0)
// and the SHA-256 DMA (master 1). Round-robin on ties, with a bounded locked
// tenure for accelerator bursts.
// Optional build macro ARB_TIMEOUT_EN: stall timeout that completes the stuck
// access with 32'hDEADBEEF and sets the sticky arb_err_o flag.
module sha_mem_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_HOLD    = 16,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_valid_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_wstrb_i,
   output logic                m0_ready_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   input  logic                m1_valid_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_wstrb_i,
   input  logic                m1_lock_i,
   output logic                m1_ready_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                s_valid_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   output logic [DATA_W/8-1:0] s_wstrb_o,
   input  logic                s_ready_i,
   input  logic [DATA_W-1:0]   s_rdata_i,
   output logic [1:0]          grant_o,
   output logic                arb_err_o
);

   localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY0 = 2'd1,
      ST_BUSY1 = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;      // 1: accelerator was served last
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [1:0]        grant_q, grant_d;
   logic              keep_c;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic              timeout_c;
`endif

   // State, round-robin pointer, tenure counter and grant registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         hold_q  <= '0;
         grant_q <= 2'b00;
`ifdef ARB_TIMEOUT_EN
         wait_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
`ifdef ARB_TIMEOUT_EN
         wait_q  <= wait_d;
         err_q   <= err_d;
`endif
      end
   end

   // Arbitration decision and routing of the owning master onto the memory port
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      hold_d     = hold_q;
      keep_c     = 1'b0;
      s_valid_o  = 1'b0;
      s_addr_o   = '0;
      s_wdata_o  = '0;
      s_wstrb_o  = '0;
      m0_ready_o = 1'b0;
      m1_ready_o = 1'b0;
      m0_rdata_o = s_rdata_i;
      m1_rdata_o = s_rdata_i;
`ifdef ARB_TIMEOUT_EN
      timeout_c  = (state_q != ST_IDLE) && (wait_q == WAIT_W'(TIMEOUT_CYC));
      err_d      = err_q;
      wait_d     = wait_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            hold_d = '0;
            if (m0_valid_i && (!m1_valid_i || last_q)) begin
               state_d = ST_BUSY0;
            end else if (m1_valid_i) begin
               state_d = ST_BUSY1;
            end
         end
         ST_BUSY0: begin
            s_valid_o  = m0_valid_i;
            s_addr_o   = m0_addr_i;
            s_wdata_o  = m0_wdata_i;
            s_wstrb_o  = m0_wstrb_i;
            m0_ready_o = s_valid_o & s_ready_i;
            if (m0_ready_o) begin
               last_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (!m0_valid_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY1: begin
            s_valid_o  = m1_valid_i;
            s_addr_o   = m1_addr_i;
            s_wdata_o  = m1_wdata_i;
            s_wstrb_o  = m1_wstrb_i;
            m1_ready_o = s_valid_o & s_ready_i;
            keep_c     = m1_lock_i && (hold_q < HOLD_LAST);
            if (hold_q < HOLD_LAST) begin
               hold_d = hold_q + HOLD_W'(1);
            end
            if (m1_ready_o) begin
               last_d = 1'b1;
            end
            if (m1_ready_o || !m1_valid_i) begin
               state_d = keep_c ? ST_BUSY1 : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef ARB_TIMEOUT_EN
      // A stuck access is completed locally with a poison word
      if (timeout_c) begin
         s_valid_o  = 1'b0;
         m0_ready_o = (state_q == ST_BUSY0);
         m1_ready_o = (state_q == ST_BUSY1);
         m0_rdata_o = DATA_W'(32'hDEADBEEF);
         m1_rdata_o = DATA_W'(32'hDEADBEEF);
         last_d     = (state_q == ST_BUSY1);
         state_d    = ST_IDLE;
         err_d      = 1'b1;
      end
      if (timeout_c || (state_q == ST_IDLE) || (state_d != state_q) ||
          (s_valid_o && s_ready_i)) begin
         wait_d = '0;
      end else if (s_valid_o) begin
         wait_d = wait_q + WAIT_W'(1);
      end
`endif

      unique case (state_d)
         ST_BUSY0: grant_d = 2'b01;
         ST_BUSY1: grant_d = 2'b10;
         default:  grant_d = 2'b00;
      endcase
   end

   assign grant_o = grant_q;

`ifdef ARB_TIMEOUT_EN
   assign arb_err_o = err_q;
`else
   assign arb_err_o = 1'b0;
`endif

endmodule

// File: doc/sha_mem_arbiter.md
Name: sha_mem_arbiter

Overview:
Two-master arbiter that shares the single native memory port (valid/ready/addr/wdata/wstrb/rdata) of the SoC RAM between the RISC-V core (master 0) and the SHA-256 accelerator's block-fetch/digest-writeback DMA (master 1). It sits between the core/accelerator and the memory in the top level. The arbiter uses round-robin arbitration with a bounded lock tenure for accelerator bursts.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; wstrb width is DATA_W/8
MAX_HOLD, 16, max cycles master 1 may hold the port under lock (>=2)
TIMEOUT_CYC, 255, stall-cycle limit (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_valid  in  1  core request, held until m0_ready
m0_addr  in  ADDR_W  core address
m0_wdata  in  DATA_W  core write data
m0_wstrb  in  DATA_W/8  core byte strobes; 0 = read
m0_ready  out  1  core transaction complete
m0_rdata  out  DATA_W  core read data
m1_valid, m1_addr, m1_wdata, m1_wstrb  in  as m0  accelerator request
m1_lock  in  1  accelerator requests continued tenure after current transfer
m1_ready  out  1  accelerator transaction complete
m1_rdata  out  DATA_W  accelerator read data
s_valid  out  1  memory request
s_addr  out  ADDR_W  memory address
s_wdata  out  DATA_W  memory write data
s_wstrb  out  DATA_W/8  memory strobes
s_ready  in  1  memory completion
s_rdata  in  DATA_W  memory read data
grant  out  2  one-hot current owner; 00 = idle
arb_err  out  1  sticky timeout flag

Behaviour:
- Reset is synchronous: state IDLE, grant=00, last_served=1 (core wins the first tie), hold_cnt=0, arb_err=0. s_valid, m0_ready, and m1_ready are 0 while in IDLE.
- States: IDLE, BUSY0, BUSY1. Grant is registered.
- IDLE, requesters present:
  - Only m0_valid → BUSY0; only m1_valid → BUSY1.
  - Both requesting → the master not equal to last_served wins.
  - s_valid rises the cycle after the request is seen (1-cycle arbitration latency).
- BUSYk routing (combinational from master k):
  - s_valid=mk_valid; s_addr, s_wdata, s_wstrb from master k.
  - mk_ready = s_valid & s_ready; mk_rdata = s_rdata.
  - The other master's ready is 0. Its rdata is s_rdata, which is don't-care.
  - In IDLE, s_addr, s_wdata, and s_wstrb are 0.
- Completion (s_valid & s_ready) in BUSY0 → last_served=0, go to IDLE.
- BUSY1:
  - hold_cnt clears on entry and increments every BUSY1 cycle, saturating at MAX_HOLD-1.
  - On completion → last_served=1. Stay in BUSY1 if m1_lock=1 and hold_cnt<MAX_HOLD-1; otherwise go to IDLE.
  - When m1_valid=0 (gap between locked transfers): stay if m1_lock=1 and hold_cnt<MAX_HOLD-1; otherwise go to IDLE.
- Master k dropping mk_valid in BUSYk without completion is a protocol violation. The arbiter returns to IDLE with last_served unchanged.
- Back-to-back: each transfer costs at least one IDLE cycle except locked m1 transfers.
- A pending core request is served at most MAX_HOLD+1 cycles after m1 lock tenure begins, plus that memory access.
- Reset asserted mid-transfer: next edge forces IDLE and s_valid drops. The in-flight access is abandoned and the master sees no ready.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: wait_cnt counts cycles with s_valid=1 & s_ready=0 and clears on completion/state change. When wait_cnt reaches TIMEOUT_CYC:
  - The arbiter forces mk_ready=1 for one cycle with mk_rdata=32'hDEADBEEF.
  - s_valid is deasserted in that cycle.
  - arb_err is set (sticky until rst) and the FSM goes to IDLE, with last_served=k.
- Not defined: no counter; the arbiter waits indefinitely for s_ready; arb_err is tied 0.

Test Plan:
- Core only: m0 read addr 0x10, memory ready after 2 cycles with rdata 0x12345678 → s_valid one cycle after m0_valid, m0_ready 1 cycle, m0_rdata=0x12345678, grant=01 then 00.
- Simultaneous first requests after reset: m0 and m1 both valid → core served first (grant=01), then accelerator (grant=10); repeat → alternates.
- Accelerator burst: m1_lock=1, 4 writes to 0x200..0x20C, wstrb=F, memory ready every cycle → all 4 complete in BUSY1 without IDLE gaps, core request held off until lock drops.
- Lock cap: m1_lock stuck 1, m1 valid continuously, m0 waiting, MAX_HOLD=16 → BUSY1 exits by cycle 16, core granted next, then m1 regains.
- Reset mid-transfer: rst pulsed while BUSY1 with s_ready=0 → next cycle s_valid=0, grant=00, no m1_ready.
- With ARB_TIMEOUT_EN, TIMEOUT_CYC=8, s_ready tied 0, m0 read → m0_ready pulse after 8 stall cycles, m0_rdata=0xDEADBEEF, arb_err=1 until reset.
